code_onehot_decoder: RTL and testbench
======================================

# code_onehot_decoder

Buffered 2-to-4 decoder that reverses the team's 4-to-2 priority encoder. It accepts encoded codes `{v, y[1:0]}` over a valid/ready handshake and stores them in a small show-ahead FIFO. It emits the matching one-hot vector `d[3:0]` over a second valid/ready handshake. It sits on the return path after the encoder, so that codes produced while the consumer is stalled are held rather than lost.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  decoder can accept a code; equals !full.
- in_y  input  2  encoded index.
- in_v  input  1  encoded valid flag (0 = no bit set).
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  downstream accepts out_d.
- out_d  output  4  decoded one-hot vector of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Push: a push occurs when in_valid && in_ready. The entry {in_v, in_y} is written at the write pointer, and the write pointer increments.
- Pop: a pop occurs when out_valid && out_ready. The read pointer increments.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count tracks occupancy: +1 on push only, −1 on pop only, unchanged when push and pop happen together.
- Decode of the head entry, combinational from FIFO storage:
  - v=1, y=00 → 1000
  - v=1, y=01 → 0100
  - v=1, y=10 → 0010
  - v=1, y=11 → 0001
  - v=0 → 0000, whatever y is.
- When empty, out_d is forced to 0000.
- Full (count==DEPTH):
  - in_ready=0.
  - A pop in that cycle does not enable a same-cycle push. There is no pass-through; in_ready depends only on registered count.
- Empty (count==0):
  - out_valid=0. A push in that cycle is not visible at the output until the next cycle; there is no bypass.
  - out_ready is ignored.
- Simultaneous push and pop when 0<count<DEPTH: both occur, and count holds.
- Upstream holding in_valid while in_ready=0 is legal. Nothing is written, and in_y/in_v may change freely.
- Downstream must see out_d stable while out_valid=1 and out_ready=0.
- X or Z on in_y while in_valid=0 is never captured.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - count=0
  - pointers=0
  - out_valid=0
  - out_d=0000
  - in_ready=1
- Storage contents are don't-care after reset.
- Latency: a code pushed at edge N is presented on out_d/out_valid after edge N, i.e. visible from cycle N+1 when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all entries are discarded immediately. out_valid drops asynchronously and no partial entry is emitted afterwards.
- in_ready, out_valid and count are registered-state-derived only; there is no combinational path from in_valid or out_ready.

## Configuration
- Macro `ONEHOT_DEC_DROP_INVALID_EN`.
- Defined: a handshaken input with in_v=0 is accepted (in_ready semantics unchanged) but not written. Pointers and count do not change, and no 0000 vector is ever emitted.
- Undefined: in_v=0 entries are stored and emitted as out_d=0000 with out_valid=1, like any other entry.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with 2 entries stored → count=0, out_valid=0, out_d=0000, in_ready=1 immediately, without waiting for a clock edge.
- Decode map: push (v=1,y=00),(1,01),(1,10),(1,11) with out_ready=1 → out_d sequence 1000, 0100, 0010, 0001. Each appears one cycle after its push.
- Full/backpressure (DEPTH=4): hold out_ready=0 and push 5 codes → in_ready=0 after the 4th, count=4, the 5th is not stored. Then pop one with in_valid still high → the 5th is accepted on the following cycle, not the pop cycle.
- Wrap and simultaneous: run continuous push+pop for 10 codes with count held at 2 → output order matches input order, count stays 2, and pointers wrap twice.
- Invalid code: push (v=0,y=11) →
  - without the macro: out_d=0000 with out_valid=1, count 0→1;
  - with the macro: count stays 0 and out_valid stays 0.
- Stall stability: out_ready=0 for 3 cycles with head=(1,10) → out_d holds 0010 and out_valid holds 1 throughout.

Source files
------------

// File: rtl/code_onehot_decoder.sv
// Buffered 2-to-4 decoder: queues encoded {v, y} codes in a show-ahead FIFO and emits one-hot vectors.
// Optional build macro ONEHOT_DEC_DROP_INVALID_EN: accept but discard codes with v=0.
module code_onehot_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_y,
  input  logic                       in_v,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_d,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
  // valid must not depend on ready; in_ready and out_valid come from registered count
  // only, so neither side sees a combinational path through this block.

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          write;
  logic          pop;
  logic [2:0]    head;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

`ifdef ONEHOT_DEC_DROP_INVALID_EN
  // Codes with v=0 complete the handshake but never occupy an entry.
  assign write = push && in_v;
`else
  assign write = push;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (write && !pop)      count <= count + CW'(1);
      else if (!write && pop) count <= count - CW'(1);
    end
  end

  // Storage is not reset; entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= {in_v, in_y};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_d = 4'b0000;
    if (!empty && head[2]) begin
      case (head[1:0])
        2'b00:   out_d = 4'b1000;
        2'b01:   out_d = 4'b0100;
        2'b10:   out_d = 4'b0010;
        default: out_d = 4'b0001;
      endcase
    end
  end

endmodule

// File: tb/tb_code_onehot_decoder.sv
// Bench for code_onehot_decoder: table-driven decode vectors, a scoreboard queue, and
// hand-written sequences for reset, backpressure, wrap, invalid codes and stalls.
module tb_code_onehot_decoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_y = 2'b00;
  logic          in_v = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_d;
  logic [CW-1:0] count;

  code_onehot_decoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_v      (in_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .count     (count)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference decode
  function automatic logic [3:0] dec(input logic v, input logic [1:0] y);
    if (!v) return 4'b0000;
    case (y)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // ---------------- scoreboard
  logic [3:0] exp_q[$];
  bit         mon_en = 1'b0;

  // Inputs change just after posedge, so at negedge they hold the values the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (mon_en) begin
      int  sz;
      bit  model_ready;
      sz = exp_q.size();
      model_ready = (sz < DEPTH);
      chk("count", int'(count), sz);
      chk("in_ready", int'(in_ready), int'(model_ready));
      chk("out_valid", int'(out_valid), int'(sz != 0));
      if (sz == 0) chk("out_d_empty", int'(out_d), 0);
      if (sz != 0 && out_ready) chk("out_d_order", int'(out_d), int'(exp_q.pop_front()));
`ifdef ONEHOT_DEC_DROP_INVALID_EN
      if (in_valid && model_ready && in_v) exp_q.push_back(dec(in_v, in_y));
`else
      if (in_valid && model_ready) exp_q.push_back(dec(in_v, in_y));
`endif
    end
  end

  // ---------------- driver tasks
  task automatic drive(input logic iv, input logic v, input logic [1:0] y, input logic ordy);
    in_valid  = iv;
    in_v      = v;
    in_y      = y;
    out_ready = ordy;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    cycle();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic [3:0] d;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{v: 1'b1, y: 2'b00, d: 4'b1000};
    tbl[1] = '{v: 1'b1, y: 2'b01, d: 4'b0100};
    tbl[2] = '{v: 1'b1, y: 2'b10, d: 4'b0010};
    tbl[3] = '{v: 1'b1, y: 2'b11, d: 4'b0001};

    // Reset state
    repeat (2) cycle();
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_d", int'(out_d), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    cycle();
    mon_en = 1'b1;

    // Decode map: each code visible one cycle after its push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[i].v, tbl[i].y, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 2'b00, 1'b1);
      chk("map_valid", int'(out_valid), 1);
      chk("map_d", int'(out_d), int'(tbl[i].d));
      cycle();
    end
    drain(10);

    // Full / backpressure: 5 codes offered with out_ready=0
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'(i), 1'b0);
      cycle();
    end
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    drive(1'b1, 1'b1, 2'b00, 1'b1);   // 5th code still offered, one pop
    cycle();
    out_ready = 1'b0;
    chk("pop_cycle_count", int'(count), 3);
    chk("pop_cycle_in_ready", int'(in_ready), 1);
    cycle();
    in_valid = 1'b0;
    chk("late_push_count", int'(count), 4);
    drain(20);

    // Wrap + simultaneous push/pop with count held at 2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 2'(i + 2), 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
      cycle();
      chk("wrap_count", int'(count), 2);
    end
    drain(20);

    // Invalid code
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    cycle();
    in_valid = 1'b0;
`ifdef ONEHOT_DEC_DROP_INVALID_EN
    chk("inv_count", int'(count), 0);
    chk("inv_out_valid", int'(out_valid), 0);
`else
    chk("inv_count", int'(count), 1);
    chk("inv_out_valid", int'(out_valid), 1);
    chk("inv_out_d", int'(out_d), 0);
`endif
    drain(10);

    // Stall stability with head=(1,10)
    drive(1'b1, 1'b1, 2'b10, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_d", int'(out_d), 4'b0010);
      chk("stall_valid", int'(out_valid), 1);
      cycle();
    end
    drain(10);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
      cycle();
    end
    drain(20);

    // Mid-cycle asynchronous reset with 2 entries stored
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 2'(i), 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", int'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_count", int'(count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_d", int'(out_d), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_rst_out_valid", int'(out_valid), 0);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
